// File: rtl/cache_control_pkg.sv
// Shared types for the cache controller: FSM state encoding, datapath select
// constants and a lowest-set-bit helper used for way priority.
package cache_types;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_COMPARE   = 2'd1,
      S_WRITEBACK = 2'd2,
      S_ALLOCATE  = 2'd3
   } cache_state_t;

   localparam logic pmem_addr_req    = 1'b0;
   localparam logic pmem_addr_victim = 1'b1;
   localparam logic datain_pmem      = 1'b0;
   localparam logic datain_cpu       = 1'b1;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic logic [2:0] lowest_set(input logic [7:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         r = v[i] ? 3'(i) : r;
      end
      return r;
   endfunction

endpackage

// File: rtl/cache_control_if.sv
// Bundle of CPU handshake, datapath control and physical-memory signals seen by
// the cache controller. master = controller side, slave = datapath/memory side.
interface cache_control_if #(
   parameter int WAYS = 2,
   parameter int SETS = 8
);
   localparam int IDX_W = $clog2(SETS);
   localparam int WAY_W = $clog2(WAYS);

   logic             mem_read;
   logic             mem_write;
   logic [IDX_W-1:0] mem_index;
   logic [WAYS-1:0]  hit;
   logic [WAYS-1:0]  valid;
   logic [WAYS-1:0]  dirty;
   logic             mem_resp;
   logic [WAY_W-1:0] way_sel;
   logic             load_data;
   logic             load_tag;
   logic             load_valid;
   logic             load_dirty;
   logic             dirty_in;
   logic             datain_sel;
   logic             pmem_addr_sel;
   logic             pmem_read;
   logic             pmem_write;
   logic             pmem_resp;

   modport master (
      input  mem_read, mem_write, mem_index, hit, valid, dirty, pmem_resp,
      output mem_resp, way_sel, load_data, load_tag, load_valid, load_dirty,
             dirty_in, datain_sel, pmem_addr_sel, pmem_read, pmem_write
   );

   modport slave (
      output mem_read, mem_write, mem_index, hit, valid, dirty, pmem_resp,
      input  mem_resp, way_sel, load_data, load_tag, load_valid, load_dirty,
             dirty_in, datain_sel, pmem_addr_sel, pmem_read, pmem_write
   );

endinterface

// File: rtl/cache_control_plru.sv
// Per-set tree pseudo-LRU: heap-ordered node bits (node 0 = root, bit 1 means
// the victim is in the upper half), victim walk and access update for one set.
module cache_plru #(
   parameter  int WAYS  = 2,
   parameter  int SETS  = 8,
   localparam int IDX_W = $clog2(SETS),
   localparam int WAY_W = $clog2(WAYS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] i_index,
   input  logic             i_upd_en,
   input  logic [WAY_W-1:0] i_upd_way,
   output logic [WAY_W-1:0] o_victim
);

   logic [WAYS-2:0] r_tree [SETS];
   logic [WAYS-2:0] w_cur;
   logic [WAYS-2:0] w_next;

   // Walk the indexed tree for the victim and build the post-access tree.
   always_comb begin
      logic b;
      int   v_node;
      int   u_node;
      w_cur    = r_tree[i_index];
      w_next   = w_cur;
      o_victim = '0;
      v_node   = 0;
      u_node   = 0;
      for (int l = 0; l < WAY_W; l++) begin
         b = 1'b0;
         for (int n = 0; n < WAYS - 1; n++) begin
            b         = b | ((n == v_node) & w_cur[n]);
            w_next[n] = (n == u_node) ? ~i_upd_way[WAY_W-1-l] : w_next[n];
         end
         o_victim[WAY_W-1-l] = b;
         v_node = 2 * v_node + 1 + int'(b);
         u_node = 2 * u_node + 1 + int'(i_upd_way[WAY_W-1-l]);
      end
   end

   // Tree storage; only the accessed set is rewritten.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            r_tree[s] <= '0;
         end
      end else if (i_upd_en) begin
         r_tree[i_index] <= w_next;
      end
   end

endmodule

// File: rtl/cache_control.sv
// Write-back set-associative cache control FSM with victim selection and
// write-back sequencing. Define CACHE_PERF_EN to add hit/miss/write-back counters.
module cache_control
   import cache_types::*;
#(
   parameter int WAYS = 2,
   parameter int SETS = 8
) (
   input logic              clk,
   input logic              rst,
   cache_control_if.master  bus
`ifdef CACHE_PERF_EN
   ,
   output logic [31:0]      hit_count,
   output logic [31:0]      miss_count,
   output logic [31:0]      wb_count
`endif
);

   localparam int WAY_W = $clog2(WAYS);

   cache_state_t     r_state;
   logic [WAY_W-1:0] r_victim_q;

   logic             w_req;
   logic [WAYS-1:0]  w_eff_hit;
   logic             w_hit;
   logic [WAY_W-1:0] w_hit_way;
   logic [WAYS-1:0]  w_invalid;
   logic [WAY_W-1:0] w_plru_victim;
   logic [WAY_W-1:0] w_victim;
   logic             w_victim_dirty;
   logic             w_upd_en;

   assign w_req          = bus.mem_read | bus.mem_write;
   assign w_eff_hit      = bus.hit & bus.valid;
   assign w_hit          = |w_eff_hit;
   assign w_hit_way      = WAY_W'(lowest_set(8'(w_eff_hit)));
   assign w_invalid      = ~bus.valid;
   assign w_victim       = (|w_invalid) ? WAY_W'(lowest_set(8'(w_invalid))) : w_plru_victim;
   assign w_victim_dirty = bus.valid[w_victim] & bus.dirty[w_victim];

   cache_plru #(.WAYS(WAYS), .SETS(SETS)) u_plru (
      .clk       (clk),
      .rst       (rst),
      .i_index   (bus.mem_index),
      .i_upd_en  (w_upd_en),
      .i_upd_way (w_hit_way),
      .o_victim  (w_plru_victim)
   );

   // Datapath strobes and pmem handshake, decoded from state and inputs.
   always_comb begin
      bus.mem_resp      = 1'b0;
      bus.way_sel       = '0;
      bus.load_data     = 1'b0;
      bus.load_tag      = 1'b0;
      bus.load_valid    = 1'b0;
      bus.load_dirty    = 1'b0;
      bus.dirty_in      = 1'b0;
      bus.datain_sel    = datain_pmem;
      bus.pmem_addr_sel = pmem_addr_req;
      bus.pmem_read     = 1'b0;
      bus.pmem_write    = 1'b0;
      w_upd_en          = 1'b0;
      case (r_state)
         S_IDLE: begin
            bus.way_sel = '0;
         end
         S_COMPARE: begin
            if (w_req && w_hit) begin
               bus.way_sel  = w_hit_way;
               bus.mem_resp = 1'b1;
               w_upd_en     = 1'b1;
               if (bus.mem_write) begin
                  bus.load_data  = 1'b1;
                  bus.datain_sel = datain_cpu;
                  bus.load_dirty = 1'b1;
                  bus.dirty_in   = 1'b1;
               end else begin
                  bus.datain_sel = datain_pmem;
               end
            end else if (w_req) begin
               bus.way_sel = w_victim;
            end else begin
               bus.way_sel = '0;
            end
         end
         S_WRITEBACK: begin
            bus.pmem_write    = 1'b1;
            bus.pmem_addr_sel = pmem_addr_victim;
            bus.way_sel       = r_victim_q;
         end
         S_ALLOCATE: begin
            bus.pmem_read = 1'b1;
            bus.way_sel   = r_victim_q;
            if (bus.pmem_resp) begin
               bus.load_data  = 1'b1;
               bus.load_tag   = 1'b1;
               bus.load_valid = 1'b1;
               bus.load_dirty = 1'b1;
            end else begin
               bus.load_data  = 1'b0;
            end
         end
         default: begin
            bus.way_sel = '0;
         end
      endcase
   end

   // Control state and the victim chosen on a miss.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_victim_q <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) r_state <= S_COMPARE;
            end
            S_COMPARE: begin
               if (!w_req || w_hit) begin
                  r_state <= S_IDLE;
               end else begin
                  r_victim_q <= w_victim;
                  r_state    <= w_victim_dirty ? S_WRITEBACK : S_ALLOCATE;
               end
            end
            S_WRITEBACK: begin
               if (bus.pmem_resp) r_state <= S_ALLOCATE;
            end
            S_ALLOCATE: begin
               if (bus.pmem_resp) r_state <= S_COMPARE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef CACHE_PERF_EN
   logic [31:0] r_hit_count;
   logic [31:0] r_miss_count;
   logic [31:0] r_wb_count;
   logic        r_refill;

   // Retry after a fill hits by construction, so the refill flag masks it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hit_count  <= 32'd0;
         r_miss_count <= 32'd0;
         r_wb_count   <= 32'd0;
         r_refill     <= 1'b0;
      end else begin
         if (r_state == S_COMPARE && w_req && w_hit && !r_refill)
            r_hit_count <= r_hit_count + 32'd1;
         if (r_state == S_COMPARE && w_req && !w_hit)
            r_miss_count <= r_miss_count + 32'd1;
         if (r_state == S_WRITEBACK && bus.pmem_resp)
            r_wb_count <= r_wb_count + 32'd1;
         if (r_state == S_ALLOCATE && bus.pmem_resp)
            r_refill <= 1'b1;
         else if (r_state == S_COMPARE)
            r_refill <= 1'b0;
      end
   end

   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;
   assign wb_count   = r_wb_count;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: a 2-way and a 4-way instance driven by a
// small tag/valid/dirty datapath model, with an event scoreboard per request.
module tb_cache_control;
   import cache_types::*;

   typedef enum int {EV_WB, EV_ALLOC, EV_FILL, EV_RESP} ev_kind_e;
   typedef struct {
      ev_kind_e kind;
      int       way;
      bit       wr;
      int       lat;
      string    name;
   } ev_t;
   typedef struct packed {
      logic       resp;
      logic [2:0] way;
      logic       ld_data, ld_tag, ld_valid, ld_dirty, dirty_in, din_sel, addr_sel, pread, pwrite;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   ev_t  sb[$];

   bit req_rd [2];
   bit req_wr [2];
   bit presp  [2];
   int req_idx[2];
   int req_tag[2];
   int mt [2][8][4];
   bit mv [2][8][4];
   bit md [2][8][4];

   cache_control_if #(.WAYS(2), .SETS(8)) bus2 ();
   cache_control_if #(.WAYS(4), .SETS(8)) bus4 ();

`ifdef CACHE_PERF_EN
   logic [31:0] hc2, mc2, wc2, hc4, mc4, wc4;
`endif

   cache_control #(.WAYS(2), .SETS(8)) u_dut2 (
      .clk(clk), .rst(rst), .bus(bus2)
`ifdef CACHE_PERF_EN
      , .hit_count(hc2), .miss_count(mc2), .wb_count(wc2)
`endif
   );

   cache_control #(.WAYS(4), .SETS(8)) u_dut4 (
      .clk(clk), .rst(rst), .bus(bus4)
`ifdef CACHE_PERF_EN
      , .hit_count(hc4), .miss_count(mc4), .wb_count(wc4)
`endif
   );

   always #5 clk = ~clk;

   always_comb begin
      bus2.mem_read  = req_rd[0];
      bus2.mem_write = req_wr[0];
      bus2.mem_index = 3'(req_idx[0]);
      bus2.pmem_resp = presp[0];
      bus2.hit   = '0;
      bus2.valid = '0;
      bus2.dirty = '0;
      for (int w = 0; w < 2; w++) begin
         bus2.hit[w]   = (mt[0][req_idx[0]][w] == req_tag[0]);
         bus2.valid[w] = mv[0][req_idx[0]][w];
         bus2.dirty[w] = md[0][req_idx[0]][w];
      end
   end

   always_comb begin
      bus4.mem_read  = req_rd[1];
      bus4.mem_write = req_wr[1];
      bus4.mem_index = 3'(req_idx[1]);
      bus4.pmem_resp = presp[1];
      bus4.hit   = '0;
      bus4.valid = '0;
      bus4.dirty = '0;
      for (int w = 0; w < 4; w++) begin
         bus4.hit[w]   = (mt[1][req_idx[1]][w] == req_tag[1]);
         bus4.valid[w] = mv[1][req_idx[1]][w];
         bus4.dirty[w] = md[1][req_idx[1]][w];
      end
   end

   function automatic obs_t obs(input int d);
      obs_t o;
      if (d == 0)
         o = '{bus2.mem_resp, 3'(bus2.way_sel), bus2.load_data, bus2.load_tag, bus2.load_valid,
               bus2.load_dirty, bus2.dirty_in, bus2.datain_sel, bus2.pmem_addr_sel,
               bus2.pmem_read, bus2.pmem_write};
      else
         o = '{bus4.mem_resp, 3'(bus4.way_sel), bus4.load_data, bus4.load_tag, bus4.load_valid,
               bus4.load_dirty, bus4.dirty_in, bus4.datain_sel, bus4.pmem_addr_sel,
               bus4.pmem_read, bus4.pmem_write};
      return o;
   endfunction

   function automatic obs_t exp_obs(input ev_t ev);
      obs_t e;
      e = '0;
      e.way = 3'(ev.way);
      case (ev.kind)
         EV_WB:    begin e.pwrite = 1'b1; e.addr_sel = 1'b1; end
         EV_ALLOC: e.pread = 1'b1;
         EV_FILL:  begin e.pread = 1'b1; e.ld_data = 1'b1; e.ld_tag = 1'b1;
                         e.ld_valid = 1'b1; e.ld_dirty = 1'b1; end
         EV_RESP:  begin
            e.resp = 1'b1;
            if (ev.wr) begin
               e.ld_data = 1'b1; e.ld_dirty = 1'b1; e.dirty_in = 1'b1; e.din_sel = 1'b1;
            end
         end
         default: e = '0;
      endcase
      return e;
   endfunction

   function automatic void push(ev_kind_e k, int way, bit wr, int lat, string name);
      sb.push_back('{k, way, wr, lat, name});
   endfunction

   // Drive one request, answer pmem after n_wb / n_alloc cycles, score each event.
   task automatic run_req(input int d, input bit wr, input int idx, input int tag,
                          input int n_wb, input int n_alloc);
      obs_t     o, e, go;
      ev_t      ev;
      ev_kind_e gk;
      int       gc, wbc, alc;
      bit       done;
      ev_kind_e got_k[$];
      obs_t     got_o[$];
      int       got_c[$];
      wbc = 0; alc = 0; done = 1'b0;
      @(negedge clk);
      req_rd[d] = !wr; req_wr[d] = wr; req_idx[d] = idx; req_tag[d] = tag;
      for (int cyc = 1; cyc <= 64 && !done; cyc++) begin
         @(negedge clk);
         presp[d] = 1'b0;
         #1 o = obs(d);
         if (o.pwrite) begin
            wbc++;
            if (wbc == 1) begin got_k.push_back(EV_WB); got_o.push_back(o); got_c.push_back(cyc); end
            if (wbc == n_wb) presp[d] = 1'b1;
         end else if (o.pread) begin
            alc++;
            if (alc == 1) begin got_k.push_back(EV_ALLOC); got_o.push_back(o); got_c.push_back(cyc); end
            if (alc == n_alloc) begin
               presp[d] = 1'b1;
               #1 o = obs(d);
               got_k.push_back(EV_FILL); got_o.push_back(o); got_c.push_back(cyc);
            end
         end else if (o.resp) begin
            got_k.push_back(EV_RESP); got_o.push_back(o); got_c.push_back(cyc);
            done = 1'b1;
         end
         if (o.ld_tag)   mt[d][idx][o.way] = tag;
         if (o.ld_valid) mv[d][idx][o.way] = 1'b1;
         if (o.ld_dirty) md[d][idx][o.way] = o.dirty_in;
         while (got_k.size() > 0) begin
            gk = got_k.pop_front(); go = got_o.pop_front(); gc = got_c.pop_front();
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_event: got kind %0d obs %h, expected no event", gk, go);
            end else begin
               ev = sb.pop_front();
               e  = exp_obs(ev);
               if (gk != ev.kind || go !== e) begin
                  n_fail++;
                  $display("FAIL %s: got kind %0d obs %h, expected kind %0d obs %h",
                           ev.name, gk, go, ev.kind, e);
               end
               if (gk == EV_RESP && ev.lat > 0) begin
                  n_checks++;
                  if (gc != ev.lat) begin
                     n_fail++;
                     $display("FAIL %s_latency: got %0d cycles, expected %0d", ev.name, gc, ev.lat);
                  end
               end
            end
         end
      end
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL timeout: no mem_resp within 64 cycles, expected a response");
      end
      @(posedge clk);
      #1;
      req_rd[d] = 1'b0; req_wr[d] = 1'b0; presp[d] = 1'b0;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL missing_events: got %0d events left, expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_reset();
      obs_t o;
      req_rd[0] = 1'b1; req_rd[1] = 1'b1;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      o = obs(0); n_checks++;
      if (o !== '0) begin n_fail++; $display("FAIL reset_outputs_w2: got %h, expected 0", o); end
      o = obs(1); n_checks++;
      if (o !== '0) begin n_fail++; $display("FAIL reset_outputs_w4: got %h, expected 0", o); end
      req_rd[0] = 1'b0; req_rd[1] = 1'b0; rst = 1'b0;
      repeat (2) @(negedge clk);
      o = obs(0); n_checks++;
      if (o !== '0) begin n_fail++; $display("FAIL idle_after_reset: got %h, expected 0", o); end
   endtask

   task automatic test_cold_read_miss();
      push(EV_ALLOC, 0, 1'b0, -1, "cold_alloc");
      push(EV_FILL,  0, 1'b0, -1, "cold_fill");
      push(EV_RESP,  0, 1'b0, 7,  "cold_resp");
      run_req(0, 1'b0, 3, 10, 0, 5);
   endtask

   task automatic test_write_hit();
      mt[0][5][0] = 1; mt[0][5][1] = 2;
      mv[0][5][0] = 1'b1; mv[0][5][1] = 1'b1;
      md[0][5][0] = 1'b0; md[0][5][1] = 1'b0;
      push(EV_RESP, 1, 1'b1, 1, "write_hit");
      run_req(0, 1'b1, 5, 2, 0, 0);
      n_checks++;
      if (md[0][5][1] !== 1'b1) begin
         n_fail++; $display("FAIL write_hit_dirty: got %0d, expected 1", md[0][5][1]);
      end
   endtask

   task automatic test_dirty_miss();
      push(EV_RESP, 0, 1'b0, 1, "read_hit_way0");
      run_req(0, 1'b0, 5, 1, 0, 0);
      push(EV_WB,    1, 1'b0, -1, "dirty_wb");
      push(EV_ALLOC, 1, 1'b0, -1, "dirty_alloc");
      push(EV_FILL,  1, 1'b0, -1, "dirty_fill");
      push(EV_RESP,  1, 1'b0, 7,  "dirty_resp");
      run_req(0, 1'b0, 5, 3, 3, 2);
   endtask

   task automatic test_plru();
      for (int w = 0; w < 4; w++) begin
         push(EV_ALLOC, w, 1'b0, -1, "plru_fill_alloc");
         push(EV_FILL,  w, 1'b0, -1, "plru_fill_load");
         push(EV_RESP,  w, 1'b0, 3,  "plru_fill_resp");
         run_req(1, 1'b0, 2, 10 + w, 0, 1);
      end
      for (int w = 0; w < 4; w++) begin
         push(EV_RESP, w, 1'b0, 1, "plru_hit");
         run_req(1, 1'b0, 2, 10 + w, 0, 0);
      end
      push(EV_ALLOC, 0, 1'b0, -1, "plru_victim_alloc");
      push(EV_FILL,  0, 1'b0, -1, "plru_victim_fill");
      push(EV_RESP,  0, 1'b0, 4,  "plru_victim_resp");
      run_req(1, 1'b0, 2, 14, 0, 2);
   endtask

   task automatic test_reset_in_alloc();
      obs_t o, e;
      mt[0][1][0] = 1; mt[0][1][1] = 2;
      mv[0][1][0] = 1'b1; mv[0][1][1] = 1'b1;
      md[0][1][0] = 1'b0; md[0][1][1] = 1'b0;
      push(EV_RESP, 0, 1'b0, 1, "pre_rst_hit");
      run_req(0, 1'b0, 1, 1, 0, 0);
      @(negedge clk);
      req_rd[0] = 1'b1; req_idx[0] = 1; req_tag[0] = 3;
      repeat (3) @(negedge clk);
      #1 o = obs(0);
      e = exp_obs('{EV_ALLOC, 1, 1'b0, -1, "alloc_before_rst"});
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL alloc_before_rst: got %h, expected %h", o, e); end
      rst = 1'b1;
      #1 o = obs(0); n_checks++;
      if (o !== '0) begin n_fail++; $display("FAIL rst_drops_pmem: got %h, expected 0", o); end
      @(negedge clk);
      o = obs(0); n_checks++;
      if (o !== '0) begin n_fail++; $display("FAIL held_in_reset: got %h, expected 0", o); end
      req_rd[0] = 1'b0; rst = 1'b0;
      push(EV_ALLOC, 0, 1'b0, -1, "post_rst_alloc");
      push(EV_FILL,  0, 1'b0, -1, "post_rst_fill");
      push(EV_RESP,  0, 1'b0, 4,  "post_rst_resp");
      run_req(0, 1'b0, 1, 3, 0, 2);
   endtask

   task automatic test_perf();
      pulse_reset();
      mt[0][4][0] = 1; mt[0][4][1] = 2;
      mv[0][4][0] = 1'b1; mv[0][4][1] = 1'b1;
      md[0][4][0] = 1'b0; md[0][4][1] = 1'b0;
      push(EV_RESP, 0, 1'b0, 1, "perf_hit0"); run_req(0, 1'b0, 4, 1, 0, 0);
      push(EV_RESP, 1, 1'b0, 1, "perf_hit1"); run_req(0, 1'b0, 4, 2, 0, 0);
      push(EV_RESP, 0, 1'b1, 1, "perf_hit2"); run_req(0, 1'b1, 4, 1, 0, 0);
      push(EV_ALLOC, 1, 1'b0, -1, "perf_clean_alloc");
      push(EV_FILL,  1, 1'b0, -1, "perf_clean_fill");
      push(EV_RESP,  1, 1'b0, 4,  "perf_clean_resp");
      run_req(0, 1'b0, 4, 5, 0, 2);
      push(EV_WB,    0, 1'b0, -1, "perf_dirty_wb");
      push(EV_ALLOC, 0, 1'b0, -1, "perf_dirty_alloc");
      push(EV_FILL,  0, 1'b0, -1, "perf_dirty_fill");
      push(EV_RESP,  0, 1'b0, 6,  "perf_dirty_resp");
      run_req(0, 1'b0, 4, 6, 2, 2);
`ifdef CACHE_PERF_EN
      n_checks++;
      if (hc2 !== 32'd3) begin n_fail++; $display("FAIL hit_count: got %0d, expected 3", hc2); end
      n_checks++;
      if (mc2 !== 32'd2) begin n_fail++; $display("FAIL miss_count: got %0d, expected 2", mc2); end
      n_checks++;
      if (wc2 !== 32'd1) begin n_fail++; $display("FAIL wb_count: got %0d, expected 1", wc2); end
`endif
   endtask

   initial begin
      for (int d = 0; d < 2; d++)
         for (int s = 0; s < 8; s++)
            for (int w = 0; w < 4; w++) begin
               mt[d][s][w] = -1; mv[d][s][w] = 1'b0; md[d][s][w] = 1'b0;
            end
      for (int d = 0; d < 2; d++) begin
         req_rd[d] = 1'b0; req_wr[d] = 1'b0; presp[d] = 1'b0;
         req_idx[d] = 0; req_tag[d] = -2;
      end
      test_reset();
      test_cold_read_miss();
      test_write_hit();
      test_dirty_miss();
      test_plru();
      test_reset_in_alloc();
      test_perf();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation time limit, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/cache_control.md
# cache_control

Parametrised control FSM for a set-associative write-back cache. It sits between the LC-3b CPU memory handshake (mem_read/mem_write/mem_resp) and physical memory (pmem_read/pmem_write/pmem_resp). It drives the cache datapath's array load and mux selects, and owns per-set tree pseudo-LRU state. It generalises the fixed multicycle control FSM to configurable associativity and set count, adding victim selection and write-back sequencing.

## Interface
- WAYS, 2, associativity; power of two, 2..8
- SETS, 8, number of sets; power of two; IDX_W = $clog2(SETS), WAY_W = $clog2(WAYS)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_read / mem_write  in  1 each  CPU request; held until mem_resp
- mem_index  in  IDX_W  set index of current request
- hit  in  WAYS  per-way tag match for indexed set
- valid / dirty  in  WAYS each  indexed-set valid/dirty bits
- mem_resp  out  1  one-cycle completion pulse
- way_sel  out  WAY_W  way addressed by data/tag/valid/dirty arrays
- load_data, load_tag, load_valid, load_dirty  out  1 each  array write strobes for way_sel
- dirty_in  out  1  value written on load_dirty
- datain_sel  out  1  0 = pmem line, 1 = CPU write merge
- pmem_addr_sel  out  1  0 = request tag, 1 = victim tag (write-back)
- pmem_read / pmem_write  out  1 each; pmem_resp  in  1
- hit_count, miss_count, wb_count  out  32 each  (only with CACHE_PERF_EN)

## Operation
- States: S_IDLE, S_COMPARE, S_WRITEBACK, S_ALLOCATE. Reset state S_IDLE.
- S_IDLE: no outputs. Goes to S_COMPARE if mem_read | mem_write.
- S_COMPARE:
  - Effective hit = (hit & valid) != 0; way_sel = lowest set bit.
  - On hit: mem_resp = 1 and PLRU updated for that way. A write hit also asserts load_data, datain_sel = 1, load_dirty, dirty_in = 1. Next state S_IDLE.
  - On miss: victim = lowest invalid way, else PLRU way; latched in victim_q. Next state is S_WRITEBACK if valid[victim] & dirty[victim], else S_ALLOCATE.
  - No request present (dropped): go to S_IDLE with no outputs.
- S_WRITEBACK: pmem_write = 1, pmem_addr_sel = 1, way_sel = victim_q. On pmem_resp, go to S_ALLOCATE.
- S_ALLOCATE: pmem_read = 1, way_sel = victim_q. On pmem_resp, pulse load_data (datain_sel = 0), load_tag, load_valid and load_dirty (dirty_in = 0), then go to S_COMPARE; the retry hits.
- Simultaneous mem_read and mem_write: treated as write.
- PLRU: tree of WAYS-1 bits per set, node 0 is the root. A node bit of 1 means the victim lies in the upper half. An access sets every node on the path to point away from the accessed way. Victim selection follows the bits from the root.

## Timing
- All outputs are combinational from state, victim_q and inputs. Every output is 0 during and after reset until a request arrives.
- Hit: request seen in S_IDLE, mem_resp in the following cycle (latency 1).
- Clean miss: 1 (S_COMPARE) + N_alloc + 1 (S_COMPARE) cycles after S_IDLE.
- Dirty miss: adds N_wb cycles of S_WRITEBACK.
- pmem_read/pmem_write are held constant until pmem_resp. The state advances on the edge where pmem_resp = 1.
- Async rst: the state goes to S_IDLE immediately; pmem strobes drop in the same cycle. PLRU bits, victim_q and the counters clear. A partially written line is not loaded.

## Configuration
- CACHE_PERF_EN defined: adds hit_count, miss_count and wb_count, all wrapping 32-bit counters.
  - hit_count increments on a first-pass hit in S_COMPARE; the post-fill retry does not count.
  - miss_count increments on a miss transition out of S_COMPARE.
  - wb_count increments on S_WRITEBACK exit.
  - Uses one refill flag register.
- CACHE_PERF_EN undefined: the three ports and all counter logic are absent; behaviour is otherwise identical.

## Structure
- The shared package cache_types holds:
  - cache_state_t enum
  - pmem address-select constants (pmem_addr_req, pmem_addr_victim)
  - datain-select constants (datain_pmem, datain_cpu)
- Sub-module cache_plru holds the SETS × (WAYS-1) bit array, victim computation for mem_index, and the update port (way, enable).
- cache_control contains only the FSM, victim_q and the optional counters.

## Test plan
- Cold read miss (WAYS=2): rst, read with mem_index = 3 and valid = 00. Expect S_ALLOCATE with way_sel = 0. pmem_resp arrives after 5 cycles; expect a load_tag/valid/data pulse. The retry with hit = 01 gives mem_resp.
- Write hit: mem_write, hit = 10, valid = 11. Expect in S_COMPARE: mem_resp, load_data, datain_sel = 1, load_dirty, dirty_in = 1, way_sel = 1.
- Dirty miss: both ways valid, PLRU points to way 1, dirty = 10. Expect S_WRITEBACK with pmem_write = 1, pmem_addr_sel = 1, way_sel = 1; then S_ALLOCATE; then mem_resp.
- PLRU (WAYS=4): fill ways 0..3 by invalid priority, then hit ways 0, 1, 2, 3 in order. The next miss must select victim way 0.
- rst asserted 2 cycles into S_ALLOCATE: pmem_read = 0 in the same cycle, no load strobes, and the next request sees PLRU victim way 0.
- With CACHE_PERF_EN: 3 hits, 1 clean miss and 1 dirty miss must give hit_count = 3, miss_count = 2, wb_count = 1.
